pipe_skid_buf: RTL and testbench

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

---
 rtl/pipe_skid_buf.sv | 89 ++++++++
 tb/tb_pipe_skid_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf.sv
// Two-entry registered skid buffer: main drives the output, skid absorbs one extra beat.
// Latency 1 cycle; in_ready_o/out_valid_o/count_o are flops, so no input-to-output combinational path.
module pipe_skid_buf #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DWIDTH-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DWIDTH-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] skid;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  // Status outputs are updated alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      count_o     <= 2'd0;
      out_data_o  <= '0;
      skid        <= '0;
    end else if (flush_i) begin
      // out_data_o deliberately keeps its last value; only occupancy is dropped.
      state       <= EMPTY;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      count_o     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_data_o  <= in_data_i;
            state       <= BUSY;
            out_valid_o <= 1'b1;
            count_o     <= 2'd1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            out_data_o <= in_data_i;
          end else if (in_xfer) begin
            skid       <= in_data_i;
            state      <= FULL;
            in_ready_o <= 1'b0;
            count_o    <= 2'd2;
          end else if (out_xfer) begin
            state       <= EMPTY;
            out_valid_o <= 1'b0;
            count_o     <= 2'd0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_data_o <= skid;
            state      <= BUSY;
            in_ready_o <= 1'b1;
            count_o    <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          count_o     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_skid_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: contents in arrival order, plus the value the output should show.
  logic [31:0] q[$];
  logic [31:0] exp_data;

  pipe_skid_buf #(.DWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .count_o    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock, apply the buffer's rules to the model, then settle for sampling.
  task automatic step();
    bit in_x;
    bit out_x;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_data = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      in_x  = in_valid && (q.size() < 2);
      out_x = out_ready && (q.size() > 0);
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(in_data);
    end
    if (q.size() > 0) exp_data = q[0];
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        n_bad++; $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, vals[i]);
      end
      n_cmp++; if (count !== 2'd1 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL stream_count[%0d]: got cnt=%0d rdy=%b expected cnt=1 rdy=1", i, count, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin
      n_bad++; $display("FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, count);
    end
    n_cmp++; if (out_data !== 32'h33) begin n_bad++; $display("FAIL empty_retain: got %h expected 33", out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    n_cmp++; if (count !== 2'd1 || out_data !== 32'hA) begin
      n_bad++; $display("FAIL bp_first: got cnt=%0d d=%h expected cnt=1 d=a", count, out_data);
    end
    in_data = 32'hB;
    step();
    n_cmp++; if (count !== 2'd2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full: got cnt=%0d rdy=%b expected cnt=2 rdy=0", count, in_ready);
    end
    in_data = 32'hC;
    step(); step();
    n_cmp++; if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold: got cnt=%0d rdy=%b v=%b d=%h expected cnt=2 rdy=0 v=1 d=a",
                        count, in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_drain();
    logic [31:0] seen [3];
    seen[0] = out_data;
    out_ready = 1'b1;
    step();
    seen[1] = out_valid ? out_data : 32'hFFFF_FFFF;
    step();
    seen[2] = out_valid ? out_data : 32'hFFFF_FFFF;
    in_valid = 1'b0;
    n_cmp++; if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
      n_bad++; $display("FAIL drain_order: got %h %h %h expected a b c", seen[0], seen[1], seen[2]);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin
      n_bad++; $display("FAIL drain_empty: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_flush();
    bit leaked = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h1111; step();
    in_data = 32'h2222; step();
    n_cmp++; if (count !== 2'd2) begin n_bad++; $display("FAIL flush_pre: got cnt=%0d expected 2", count); end
    flush = 1'b1; in_data = 32'h5A5A;
    step();
    flush = 1'b0;
    n_cmp++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_state: got cnt=%0d v=%b rdy=%b expected cnt=0 v=0 rdy=1", count, out_valid, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid && out_data == 32'h5A5A) leaked = 1'b1;
    end
    n_cmp++; if (leaked !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_leak: got leaked=%b v=%b expected leaked=0 v=0", leaked, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hDEADBEEF; step();
    in_data = 32'h0BADF00D; step();
    n_cmp++; if (count !== 2'd2 || out_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL rstmid_pre: got cnt=%0d d=%h expected cnt=2 d=deadbeef", count, out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0) begin
      n_bad++; $display("FAIL rstmid_state: got d=%h v=%b rdy=%b cnt=%0d expected d=0 v=0 rdy=1 cnt=0",
                        out_data, out_valid, in_ready, count);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 299) == 0);
      step();
      n_cmp++; if (count !== 2'(q.size())) begin
        n_bad++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, count, q.size());
      end
      n_cmp++; if (in_ready !== (q.size() < 2)) begin
        n_bad++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, in_ready, q.size() < 2);
      end
      n_cmp++; if (out_valid !== (q.size() > 0)) begin
        n_bad++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", cyc, out_valid, q.size() > 0);
      end
      n_cmp++; if (out_data !== exp_data) begin
        n_bad++; $display("FAIL rnd_out_data@%0d: got %h expected %h", cyc, out_data, exp_data);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
